// File: rtl/real_accum_pkg.sv
// rtl/real_accum_pkg.sv - state type, width helper and round-robin pick function for the shared accumulator
package real_accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } accum_state_e;

    localparam int RR_MAX_N = 8;

    // One guard bit beyond log2(count) keeps the worst-case negative sum representable.
    function automatic int acc_width(input int width, input int count);
        return width + $clog2(count) + 1;
    endfunction

    function automatic logic [RR_MAX_N-1:0] rr_pick(
        input logic [RR_MAX_N-1:0] valid,
        input logic [2:0]          ptr,
        input int                  n
    );
        logic [RR_MAX_N-1:0] grant;
        logic                found;
        logic [31:0]         idx;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= RR_MAX_N; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && (i <= n) && valid[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-input round-robin one-hot arbiter with a persistent last-grant pointer
module rr_arbiter
    import real_accum_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cke,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_next;
    logic [RR_MAX_N-1:0] req_ext;
    logic [2:0]          ptr_ext;
    logic [N-1:0]        pick;

    always_comb begin
        req_ext = '0;
        req_ext[N-1:0] = req;
        ptr_ext = '0;
        ptr_ext[PTR_W-1:0] = ptr;
        pick = N'(rr_pick(req_ext, ptr_ext, N));
        gnt  = (en && cke) ? pick : '0;
        ptr_next = ptr;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                ptr_next = PTR_W'(k);
            end
        end
    end

    // Starting at N-1 gives requester 0 first priority after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PTR_W'(N - 1);
        end else if (cke && (|gnt)) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/real_rr_accum_ctrl.sv
// rtl/real_rr_accum_ctrl.sv - round-robin shared fixed-point accumulator; optional REAL_ACC_STALL_CNT_EN adds stall_cnt_o
module real_rr_accum_ctrl
    import real_accum_pkg::*;
#(
    parameter int  N     = 2,
    parameter int  WIDTH = 16,
    parameter int  EXP   = -8,
    parameter int  COUNT = 4,
    localparam int ACC_W = acc_width(WIDTH, COUNT)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cke_i,
    input  logic               start_i,
    input  logic [N-1:0]       in_valid_i,
    input  logic [N*WIDTH-1:0] in_data_i,
    output logic [N-1:0]       in_ready_o,
    output logic               out_valid_o,
    output logic [ACC_W-1:0]   out_data_o,
    input  logic               out_ready_i,
    output logic               busy_o
`ifdef REAL_ACC_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt_o
`endif
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    // EXP only names the fixed-point scale; the sum keeps the input exponent.
    localparam int unused_exp = EXP;

    accum_state_e     state;
    accum_state_e     state_next;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     gnt;
    logic [WIDTH-1:0] sel_data;
    logic [ACC_W-1:0] sel_ext;
    logic             accept;
    logic             last_accept;
    logic             out_hs;

    rr_arbiter #(.N(N)) u_arb (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .cke   (cke_i),
        .en    (state == ACC),
        .req   (in_valid_i),
        .gnt   (gnt)
    );

    assign in_ready_o  = gnt;
    assign accept      = |gnt;
    assign last_accept = accept && (cnt == CNT_W'(COUNT - 1));
    assign out_hs      = cke_i && (state == HOLD) && out_ready_i;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                sel_data = in_data_i[k*WIDTH +: WIDTH];
            end
        end
        sel_ext = {{(ACC_W-WIDTH){sel_data[WIDTH-1]}}, sel_data};
    end

    always_comb begin
        state_next  = state;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        busy_o      = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (cke_i && start_i) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                if (last_accept) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid_o = 1'b1;
                out_data_o  = acc;
                if (out_hs) begin
                    state_next = start_i ? ACC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else if (cke_i) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc <= '0;
            cnt <= '0;
        end else if (cke_i) begin
            if ((state == IDLE) && start_i) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= acc + sel_ext;
                cnt <= last_accept ? '0 : cnt + 1'b1;
            end else if (out_hs) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end

`ifdef REAL_ACC_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (cke_i && (state == HOLD) && !out_ready_i && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_real_rr_accum_ctrl.sv
// tb/tb_real_rr_accum_ctrl.sv - directed self-checking bench for real_rr_accum_ctrl (N=2, WIDTH=16, COUNT=4)
module tb_real_rr_accum_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cke;
    logic        start;
    logic [1:0]  valid;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [31:0] in_data;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic [18:0] out_data;
    logic        out_ready;
    logic        busy;
`ifdef REAL_ACC_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    assign in_data = {data1, data0};

    real_rr_accum_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cke_i       (cke),
        .start_i     (start),
        .in_valid_i  (valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .busy_o      (busy)
`ifdef REAL_ACC_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_grant(input string tag, input logic [1:0] exp_ready);
        #1;
        check_eq(tag, {30'd0, in_ready}, {30'd0, exp_ready});
        tick();
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic release_hold(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cke = 1'b1; start = 1'b0; valid = 2'b00;
        data0 = '0; data1 = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {13'd0, out_data}, 32'd0);
        check_eq("rst_in_ready", {30'd0, in_ready}, 32'd0);
`ifdef REAL_ACC_STALL_CNT_EN
        check_eq("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Frame 1: fairness, 1.0 + 0.5 alternating -> 3.0
        valid = 2'b11; data0 = 16'h0100; data1 = 16'h0080; start = 1'b1;
        #1;
        check_eq("idle_ready", {30'd0, in_ready}, 32'd0);
        tick();
        start = 1'b0;
        check_eq("f1_busy", {31'd0, busy}, 32'd1);
        step_grant("f1_g0", 2'b01);
        step_grant("f1_g1", 2'b10);
        step_grant("f1_g2", 2'b01);
        check_eq("f1_early_valid", {31'd0, out_valid}, 32'd0);
        step_grant("f1_g3", 2'b10);
        check_eq("f1_valid", {31'd0, out_valid}, 32'd1);
        check_eq("f1_sum", {13'd0, out_data}, 32'h0000_0300);
        check_eq("f1_hold_ready", {30'd0, in_ready}, 32'd0);
        release_hold("f1");

        // Frame 2: four times -128.0
        data0 = 16'h8000; data1 = 16'h8000;
        start_frame();
        step_grant("f2_g0", 2'b01);
        step_grant("f2_g1", 2'b10);
        step_grant("f2_g2", 2'b01);
        step_grant("f2_g3", 2'b10);
        check_eq("f2_sum_neg", {13'd0, out_data}, 32'h0006_0000);
        release_hold("f2");

        // Frame 3: four times max positive
        data0 = 16'h7FFF; data1 = 16'h7FFF;
        start_frame();
        step_grant("f3_g0", 2'b01);
        step_grant("f3_g1", 2'b10);
        step_grant("f3_g2", 2'b01);
        step_grant("f3_g3", 2'b10);
        check_eq("f3_sum_pos", {13'd0, out_data}, 32'h0001_FFFC);
        release_hold("f3");

        // Frame 4: backpressure, 2*(-1.0) + 2*(0.25) = -1.5
        data0 = 16'hFF00; data1 = 16'h0040;
        start_frame();
        step_grant("f4_g0", 2'b01);
        step_grant("f4_g1", 2'b10);
        step_grant("f4_g2", 2'b01);
        step_grant("f4_g3", 2'b10);
        for (int i = 0; i < 5; i++) begin
            check_eq("f4_bp_valid", {31'd0, out_valid}, 32'd1);
            check_eq("f4_bp_data", {13'd0, out_data}, 32'h0007_FE80);
            check_eq("f4_bp_ready", {30'd0, in_ready}, 32'd0);
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        check_eq("f4_bp_after", {13'd0, out_data}, 32'h0007_FE80);
`ifdef REAL_ACC_STALL_CNT_EN
        check_eq("f4_stall_cnt", {16'd0, stall_cnt}, 32'd5);
`endif
        release_hold("f4");

        // Frame 5: clock-enable gap mid-frame, last sample only from requester 0
        data0 = 16'h0010; data1 = 16'h0020;
        start_frame();
        step_grant("f5_g0", 2'b01);
        step_grant("f5_g1", 2'b10);
        cke = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("f5_gate_ready", {30'd0, in_ready}, 32'd0);
            check_eq("f5_gate_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        cke = 1'b1;
        step_grant("f5_g2", 2'b01);
        check_eq("f5_cnt_frozen", {31'd0, out_valid}, 32'd0);
        valid = 2'b01;
        step_grant("f5_g3", 2'b01);
        check_eq("f5_sum", {13'd0, out_data}, 32'h0000_0050);

        // Frame 6: back-to-back start in the handshake cycle; pointer continues after requester 0
        valid = 2'b11; data0 = 16'h0001; data1 = 16'h0002;
        out_ready = 1'b1; start = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        check_eq("f6_b2b_busy", {31'd0, busy}, 32'd1);
        check_eq("f6_b2b_valid", {31'd0, out_valid}, 32'd0);
        step_grant("f6_g0", 2'b10);
        step_grant("f6_g1", 2'b01);
        step_grant("f6_g2", 2'b10);
        step_grant("f6_g3", 2'b01);
        check_eq("f6_sum", {13'd0, out_data}, 32'h0000_0006);
        release_hold("f6");

        // Frame 7: asynchronous reset mid-frame
        start_frame();
        step_grant("f7_g0", 2'b10);
        step_grant("f7_g1", 2'b01);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("f7_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("f7_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("f7_rst_ready", {30'd0, in_ready}, 32'd0);
        check_eq("f7_rst_data", {13'd0, out_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        start_frame();
        step_grant("f7_first_grant", 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
